// File: rtl/sha1_pkg.sv
// sha1_pkg: shared loader state encoding, sizing constants and word byte-swap helper
package sha1_pkg;
    typedef enum logic [2:0] {IDLE, FILL, LAST, KICK, HOLD, WAIT, DIGEST, FINISH} state_t;
    localparam int WORD_BYTES = 4;
    localparam int DIGEST_WORDS = 5;
    function automatic logic [31:0] change_endian(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/sha1_msg_loader_if.sv
// sha1_msg_loader_if: byte stream handshake feeding the message loader
interface sha1_msg_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    modport master (output byte_valid, byte_data, input byte_ready);
    modport slave (input byte_valid, byte_data, output byte_ready);
endinterface

// File: rtl/sha1_byte_packer.sv
// sha1_byte_packer: packs message bytes little-endian into 32-bit words and flags word/message end
module sha1_byte_packer
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    input  logic [31:0] size,
    output logic [31:0] word,
    output logic        word_done,
    output logic        last
);
    logic [31:0] count;
    logic [31:0] acc;
    logic [1:0]  lane;
    assign lane      = count[1:0];
    assign word      = acc | ({24'b0, data} << {lane, 3'b0});
    assign last      = count + 32'd1 == size;
    assign word_done = lane == 2'(WORD_BYTES - 1) || last;
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            acc   <= '0;
        end else if (take) begin
            count <= count + 32'd1;
            acc   <= word_done ? '0 : word;
        end
    end
endmodule

// File: rtl/sha1_msg_loader.sv
// sha1_msg_loader: streams a message into SRAM, kicks the SHA-1 hasher and stores its digest
module sha1_msg_loader
    import sha1_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       msg_size,
    input  logic [ADDR_W-1:0] digest_addr,
    sha1_msg_loader_if.slave  bs,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic [31:0]       port_A_data_in,
    output logic              port_A_we,
    output logic              start_hash,
    output logic [31:0]       message_addr,
    output logic [31:0]       message_size,
    input  logic [159:0]      hash,
    input  logic              hash_done,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);
    state_t            state;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] dig_addr;
    logic [159:0]      hreg;
    logic [2:0]        dcnt;
    logic [31:0]       word;
    logic              word_done;
    logic              last;
    logic              take;
    assign port_A_clk = clk;
    assign take       = bs.byte_valid & bs.byte_ready;
    sha1_byte_packer packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .take      (take),
        .data      (bs.byte_data),
        .size      (message_size),
        .word      (word),
        .word_done (word_done),
        .last      (last)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bs.byte_ready  <= 1'b0;
            port_A_we      <= 1'b0;
            port_A_addr    <= '0;
            port_A_data_in <= '0;
            start_hash     <= 1'b0;
            message_addr   <= '0;
            message_size   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            waddr          <= '0;
            dig_addr       <= '0;
            hreg           <= '0;
            dcnt           <= '0;
        end else begin
            port_A_we  <= 1'b0;
            start_hash <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: if (load_start) begin
                    message_addr  <= 32'(base_addr);
                    message_size  <= msg_size;
                    waddr         <= base_addr;
                    dig_addr      <= digest_addr;
                    busy          <= 1'b1;
                    bs.byte_ready <= msg_size != 0;
                    start_hash    <= msg_size == 0;
                    state         <= msg_size == 0 ? KICK : FILL;
                end
                FILL: if (take) begin
                    if (word_done) begin
                        port_A_we      <= 1'b1;
                        port_A_addr    <= waddr;
                        port_A_data_in <= word;
                        waddr          <= waddr + STEP;
                    end
                    if (last) begin
                        bs.byte_ready <= 1'b0;
                        state         <= LAST;
                    end
                end
                LAST: begin
                    start_hash <= 1'b1;
                    state      <= KICK;
                end
                KICK: state <= HOLD;
                HOLD: state <= WAIT;
                WAIT: if (hash_done) begin
                    port_A_we      <= 1'b1;
                    port_A_addr    <= dig_addr;
                    port_A_data_in <= change_endian(hash[159:128]);
                    hreg           <= {hash[127:0], 32'b0};
                    dcnt           <= 3'd1;
                    state          <= DIGEST;
                end
                DIGEST: if (dcnt == 3'(DIGEST_WORDS)) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FINISH;
                end else begin
                    port_A_we      <= 1'b1;
                    port_A_addr    <= port_A_addr + STEP;
                    port_A_data_in <= change_endian(hreg[159:128]);
                    hreg           <= hreg << 32;
                    dcnt           <= dcnt + 3'd1;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_msg_loader.sv
// tb_sha1_msg_loader: scoreboard bench checking SRAM writes, hasher kick and done timing
module tb_sha1_msg_loader;
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } ev_t;
    localparam logic [159:0] H = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [31:0] msg_size = '0;
    logic [15:0] digest_addr = '0;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic [31:0] port_A_data_in;
    logic        port_A_we;
    logic        start_hash;
    logic [31:0] message_addr;
    logic [31:0] message_size;
    logic [159:0] hash = '0;
    logic        hash_done = 1'b0;
    logic        busy;
    logic        done;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          s_cyc = 0;
    logic [15:0] cur_base;
    logic [7:0]  tb_bytes [8];
    int          tb_gaps [8];
    logic [31:0] tb_words [2];
    logic [31:0] dig_words [5];
    ev_t         q[$];
    sha1_msg_loader_if bs();
    sha1_msg_loader dut (
        .clk            (clk),
        .reset          (reset),
        .load_start     (load_start),
        .base_addr      (base_addr),
        .msg_size       (msg_size),
        .digest_addr    (digest_addr),
        .bs             (bs),
        .port_A_clk     (port_A_clk),
        .port_A_addr    (port_A_addr),
        .port_A_data_in (port_A_data_in),
        .port_A_we      (port_A_we),
        .start_hash     (start_hash),
        .message_addr   (message_addr),
        .message_size   (message_size),
        .hash           (hash),
        .hash_done      (hash_done),
        .busy           (busy),
        .done           (done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.kind = kind;
        e.a = a;
        e.d = d;
        e.c = c;
        q.push_back(e);
    endtask
    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d: got a=%h d=%h at cycle %0d, required nothing", kind, a, d, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a !== a || e.d !== d || e.c != cyc) begin
                errors++;
                $display("FAIL event: got kind=%0d a=%h d=%h cycle=%0d, required kind=%0d a=%h d=%h cycle=%0d",
                         kind, a, d, cyc, e.kind, e.a, e.d, e.c);
            end
        end
    endtask
    always @(negedge clk) begin
        if (!reset) begin
            if (port_A_we) observe(0, {16'h0, port_A_addr}, port_A_data_in);
            if (start_hash) observe(1, message_addr, message_size);
            if (done) observe(2, 32'h0, 32'h0);
        end
    end
    task automatic load(input logic [15:0] b, input logic [31:0] sz, input logic [15:0] d);
        @(negedge clk);
        load_start = 1'b1;
        base_addr = b;
        msg_size = sz;
        digest_addr = d;
        cur_base = b;
        if (sz == 0) begin
            s_cyc = cyc + 1;
            push(1, {16'h0, b}, 32'h0, s_cyc);
        end
        @(negedge clk);
        load_start = 1'b0;
        check("busy_after_load", {31'b0, busy}, 32'd1);
        check("ready_after_load", {31'b0, bs.byte_ready}, {31'b0, sz != 0});
    endtask
    task automatic send(input int n, input bit pulse);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < tb_gaps[i]; g++) begin
                bs.byte_valid = 1'b0;
                load_start = pulse && g == 0;
                if (load_start) base_addr = 16'h5555;
                @(negedge clk);
                load_start = 1'b0;
                base_addr = cur_base;
            end
            check("byte_ready_fill", {31'b0, bs.byte_ready}, 32'd1);
            bs.byte_valid = 1'b1;
            bs.byte_data = tb_bytes[i];
            if (i % 4 == 3 || i == n - 1)
                push(0, {16'h0, cur_base + 16'(4 * (i / 4))}, tb_words[i / 4], cyc + 1);
            if (i == n - 1) begin
                s_cyc = cyc + 2;
                push(1, {16'h0, cur_base}, n, s_cyc);
            end
            @(negedge clk);
        end
        bs.byte_data = 8'hEE;
        check("byte_ready_after_last", {31'b0, bs.byte_ready}, 32'd0);
        @(negedge clk);
        bs.byte_valid = 1'b0;
    endtask
    task automatic digest(input logic [15:0] d, input bit pre);
        int m;
        if (pre) m = s_cyc + 2;
        else begin
            while (cyc < s_cyc + 3) @(negedge clk);
            hash = H;
            hash_done = 1'b1;
            m = cyc;
        end
        for (int i = 0; i < 5; i++) push(0, {16'h0, d + 16'(4 * i)}, dig_words[i], m + 1 + i);
        push(2, 32'h0, 32'h0, m + 6);
        while (cyc < m + 1) @(negedge clk);
        hash_done = 1'b0;
        while (cyc < m + 5) @(negedge clk);
        check("busy_during_digest", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        @(negedge clk);
    endtask
    initial begin
        bs.byte_valid = 1'b0;
        bs.byte_data = '0;
        dig_words = '{32'h363e99a9, 32'h6a810647, 32'h71253eba, 32'h6cc25078, 32'h9dd8d09c};
        tb_gaps = '{0, 0, 0, 0, 0, 0, 0, 0};
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ready", {31'b0, bs.byte_ready}, 32'd0);
        check("rst_we", {31'b0, port_A_we}, 32'd0);
        check("rst_start", {31'b0, start_hash}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_addr", {16'h0, port_A_addr}, 32'd0);
        check("rst_data", port_A_data_in, 32'd0);
        check("rst_maddr", message_addr, 32'd0);
        check("rst_msize", message_size, 32'd0);
        reset = 1'b0;
        // "abc"
        tb_bytes = '{8'h61, 8'h62, 8'h63, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        tb_words = '{32'h00636261, 32'h0};
        load(16'h0100, 3, 16'h0200);
        send(3, 1'b0);
        digest(16'h0200, 1'b0);
        // eight bytes back-to-back
        tb_bytes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        tb_words = '{32'h03020100, 32'h07060504};
        load(16'h0400, 8, 16'h0500);
        send(8, 1'b0);
        digest(16'h0500, 1'b0);
        // empty message with stale hash_done already high
        hash = H;
        hash_done = 1'b1;
        load(16'h0700, 0, 16'h0800);
        digest(16'h0800, 1'b1);
        // same eight bytes with gaps and load_start pulses while busy
        tb_gaps = '{0, 2, 1, 3, 0, 1, 2, 0};
        load(16'h0400, 8, 16'h0500);
        send(8, 1'b1);
        digest(16'h0500, 1'b0);
        tb_gaps = '{0, 0, 0, 0, 0, 0, 0, 0};
        // address wrap for message and digest
        tb_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        tb_words = '{32'h13121110, 32'h17161514};
        load(16'hFFFC, 8, 16'hFFF8);
        send(8, 1'b0);
        digest(16'hFFF8, 1'b0);
        // reset after five of eight bytes
        load(16'h0300, 8, 16'h0600);
        for (int i = 0; i < 5; i++) begin
            check("byte_ready_pre_reset", {31'b0, bs.byte_ready}, 32'd1);
            bs.byte_valid = 1'b1;
            bs.byte_data = 8'hA0 + 8'(i);
            if (i == 3) push(0, 32'h0300, 32'ha3a2a1a0, cyc + 1);
            @(negedge clk);
        end
        bs.byte_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_we", {31'b0, port_A_we}, 32'd0);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("post_rst_ready", {31'b0, bs.byte_ready}, 32'd0);
        check("post_rst_start", {31'b0, start_hash}, 32'd0);
        check("post_rst_done", {31'b0, done}, 32'd0);
        check("post_rst_addr", {16'h0, port_A_addr}, 32'd0);
        check("post_rst_data", port_A_data_in, 32'd0);
        check("post_rst_maddr", message_addr, 32'd0);
        check("post_rst_msize", message_size, 32'd0);
        repeat (10) @(negedge clk);
        tb_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0};
        tb_words = '{32'h44332211, 32'h0};
        load(16'h0300, 4, 16'h0600);
        send(4, 1'b0);
        digest(16'h0600, 1'b0);
        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
